// File: rtl/rf_mp_scoreboard_if.sv
// rf_mp_scoreboard_if: read, writeback and reserve signals of the scoreboarded register file
interface rf_mp_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] read_register0;
    logic [ADDR_W-1:0] read_register1;
    logic [DATA_W-1:0] read_data0;
    logic [DATA_W-1:0] read_data1;
    logic              read_pending0;
    logic              read_pending1;
    logic              RegWrite0;
    logic [ADDR_W-1:0] write_register0;
    logic [DATA_W-1:0] write_data0;
    logic              RegWrite1;
    logic [ADDR_W-1:0] write_register1;
    logic [DATA_W-1:0] write_data1;
    logic              reserve_en;
    logic [ADDR_W-1:0] reserve_register;
    logic [ADDR_W:0]   pending_count;
    modport master (
        output read_register0, read_register1, RegWrite0, write_register0, write_data0,
               RegWrite1, write_register1, write_data1, reserve_en, reserve_register,
        input  read_data0, read_data1, read_pending0, read_pending1, pending_count
    );
    modport slave (
        input  read_register0, read_register1, RegWrite0, write_register0, write_data0,
               RegWrite1, write_register1, write_data1, reserve_en, reserve_register,
        output read_data0, read_data1, read_pending0, read_pending1, pending_count
    );
endinterface

// File: rtl/rf_mp_scoreboard.sv
// rf_mp_scoreboard: 2R/2W register file with optional bypass, optional zero R0 and RAW scoreboard
module rf_mp_scoreboard #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input logic clk,
    input logic rst_n,
    rf_mp_scoreboard_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending, pending_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              we0, we1, res;
    logic              hit0, hit1, rhit0, rhit1;
    // effective write/reserve enables: dropped during reset and for R0 when it is hardwired
    always_comb begin
        we0 = rf.RegWrite0 && rst_n && !(ZERO_R0 != 0 && rf.write_register0 == '0);
        we1 = rf.RegWrite1 && rst_n && !(ZERO_R0 != 0 && rf.write_register1 == '0);
        res = rf.reserve_en && rst_n && !(ZERO_R0 != 0 && rf.reserve_register == '0);
    end
    // register array: lane 1 is written last so it wins an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (we0) regs[rf.write_register0] <= rf.write_data0;
            if (we1) regs[rf.write_register1] <= rf.write_data1;
        end
    end
    // next pending bits: a reserve beats a same-cycle write since it is the newer producer
    always_comb begin
        pending_nxt = '0;
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt[i] = (res && rf.reserve_register == ADDR_W'(i)) ||
                             (pending[i] && !((we0 && rf.write_register0 == ADDR_W'(i)) ||
                                              (we1 && rf.write_register1 == ADDR_W'(i))));
            count_nxt = count_nxt + {{ADDR_W{1'b0}}, pending_nxt[i]};
        end
    end
    // scoreboard state and its popcount, updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending          <= '0;
            rf.pending_count <= '0;
        end else begin
            pending          <= pending_nxt;
            rf.pending_count <= count_nxt;
        end
    end
    // same-cycle write/reserve matches per read port
    always_comb begin
        hit0  = BYPASS != 0 && ((we0 && rf.write_register0 == rf.read_register0) ||
                                (we1 && rf.write_register1 == rf.read_register0));
        hit1  = BYPASS != 0 && ((we0 && rf.write_register0 == rf.read_register1) ||
                                (we1 && rf.write_register1 == rf.read_register1));
        rhit0 = res && rf.reserve_register == rf.read_register0;
        rhit1 = res && rf.reserve_register == rf.read_register1;
    end
    // read ports: zero R0, then bypass (lane 1 first), then the array
    always_comb begin
        rf.read_data0 = (ZERO_R0 != 0 && rf.read_register0 == '0) ? '0 :
                        (BYPASS != 0 && we1 && rf.write_register1 == rf.read_register0) ? rf.write_data1 :
                        (BYPASS != 0 && we0 && rf.write_register0 == rf.read_register0) ? rf.write_data0 :
                        regs[rf.read_register0];
        rf.read_data1 = (ZERO_R0 != 0 && rf.read_register1 == '0) ? '0 :
                        (BYPASS != 0 && we1 && rf.write_register1 == rf.read_register1) ? rf.write_data1 :
                        (BYPASS != 0 && we0 && rf.write_register0 == rf.read_register1) ? rf.write_data0 :
                        regs[rf.read_register1];
        rf.read_pending0 = pending[rf.read_register0] && !(hit0 && !rhit0);
        rf.read_pending1 = pending[rf.read_register1] && !(hit1 && !rhit1);
    end
endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// tb_rf_mp_scoreboard: directed checks of a bypassing RF and a non-bypassing zero-R0 RF
module tb_rf_mp_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total = 0;
    rf_mp_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) a_if ();
    rf_mp_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) b_if ();
    rf_mp_scoreboard #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0))
        dut_a (.clk(clk), .rst_n(rst_n), .rf(a_if));
    rf_mp_scoreboard #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(1))
        dut_b (.clk(clk), .rst_n(rst_n), .rf(b_if));
    always #5 clk = ~clk;
    assign b_if.read_register0   = a_if.read_register0;
    assign b_if.read_register1   = a_if.read_register1;
    assign b_if.RegWrite0        = a_if.RegWrite0;
    assign b_if.write_register0  = a_if.write_register0;
    assign b_if.write_data0      = a_if.write_data0;
    assign b_if.RegWrite1        = a_if.RegWrite1;
    assign b_if.write_register1  = a_if.write_register1;
    assign b_if.write_data1      = a_if.write_data1;
    assign b_if.reserve_en       = a_if.reserve_en;
    assign b_if.reserve_register = a_if.reserve_register;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic idle();
        a_if.RegWrite0 = 1'b0;
        a_if.RegWrite1 = 1'b0;
        a_if.reserve_en = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int lane, input logic [2:0] adr, input logic [15:0] d);
        if (lane == 0) begin
            a_if.RegWrite0 = 1'b1; a_if.write_register0 = adr; a_if.write_data0 = d;
        end else begin
            a_if.RegWrite1 = 1'b1; a_if.write_register1 = adr; a_if.write_data1 = d;
        end
    endtask
    task automatic rsv(input logic [2:0] adr);
        a_if.reserve_en = 1'b1;
        a_if.reserve_register = adr;
    endtask
    initial begin
        rst_n = 1'b0;
        idle();
        a_if.read_register0 = '0; a_if.read_register1 = '0;
        a_if.write_register0 = '0; a_if.write_register1 = '0;
        a_if.write_data0 = '0; a_if.write_data1 = '0;
        a_if.reserve_register = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            a_if.read_register0 = 3'(i);
            a_if.read_register1 = 3'(7 - i);
            #1;
            chk("rst_a_rd0", 32'(a_if.read_data0), 32'h0);
            chk("rst_a_rd1", 32'(a_if.read_data1), 32'h0);
            chk("rst_a_rp0", 32'(a_if.read_pending0), 32'h0);
            chk("rst_a_rp1", 32'(a_if.read_pending1), 32'h0);
            chk("rst_b_rd0", 32'(b_if.read_data0), 32'h0);
        end
        chk("rst_a_cnt", 32'(a_if.pending_count), 32'h0);
        chk("rst_b_cnt", 32'(b_if.pending_count), 32'h0);
        rst_n = 1'b1;
        tick();
        wr(0, 3'd3, 16'hAAAA);
        wr(1, 3'd5, 16'h5555);
        a_if.read_register0 = 3'd3;
        a_if.read_register1 = 3'd5;
        #1;
        chk("byp_a_rd0", 32'(a_if.read_data0), 32'hAAAA);
        chk("byp_a_rd1", 32'(a_if.read_data1), 32'h5555);
        chk("nobyp_b_rd0", 32'(b_if.read_data0), 32'h0);
        chk("nobyp_b_rd1", 32'(b_if.read_data1), 32'h0);
        tick();
        idle();
        #1;
        chk("wr_a_rd0", 32'(a_if.read_data0), 32'hAAAA);
        chk("wr_a_rd1", 32'(a_if.read_data1), 32'h5555);
        chk("wr_b_rd0", 32'(b_if.read_data0), 32'hAAAA);
        chk("wr_b_rd1", 32'(b_if.read_data1), 32'h5555);
        wr(0, 3'd2, 16'h1111);
        wr(1, 3'd2, 16'hFFFF);
        a_if.read_register0 = 3'd2;
        #1;
        chk("coll_byp_a", 32'(a_if.read_data0), 32'hFFFF);
        tick();
        idle();
        #1;
        chk("coll_a", 32'(a_if.read_data0), 32'hFFFF);
        chk("coll_b", 32'(b_if.read_data0), 32'hFFFF);
        rsv(3'd1);
        a_if.read_register0 = 3'd1;
        #1;
        chk("rsv_same_a_rp0", 32'(a_if.read_pending0), 32'h0);
        tick();
        idle();
        #1;
        chk("rsv_a_rp0", 32'(a_if.read_pending0), 32'h1);
        chk("rsv_a_cnt", 32'(a_if.pending_count), 32'h1);
        chk("rsv_b_rp0", 32'(b_if.read_pending0), 32'h1);
        chk("rsv_b_cnt", 32'(b_if.pending_count), 32'h1);
        wr(0, 3'd1, 16'hA5A5);
        #1;
        chk("clr_byp_a_rp0", 32'(a_if.read_pending0), 32'h0);
        chk("clr_nobyp_b_rp0", 32'(b_if.read_pending0), 32'h1);
        chk("clr_byp_a_rd0", 32'(a_if.read_data0), 32'hA5A5);
        tick();
        idle();
        #1;
        chk("clr_a_rp0", 32'(a_if.read_pending0), 32'h0);
        chk("clr_a_cnt", 32'(a_if.pending_count), 32'h0);
        chk("clr_b_rp0", 32'(b_if.read_pending0), 32'h0);
        chk("clr_b_cnt", 32'(b_if.pending_count), 32'h0);
        rsv(3'd1);
        wr(0, 3'd1, 16'hA5A5);
        tick();
        idle();
        #1;
        chk("setwin_a_rp0", 32'(a_if.read_pending0), 32'h1);
        chk("setwin_a_cnt", 32'(a_if.pending_count), 32'h1);
        chk("setwin_a_rd0", 32'(a_if.read_data0), 32'hA5A5);
        chk("setwin_b_rp0", 32'(b_if.read_pending0), 32'h1);
        for (int i = 0; i < 8; i++) begin
            rsv(3'(i));
            tick();
        end
        idle();
        a_if.read_register0 = 3'd0;
        a_if.read_register1 = 3'd7;
        #1;
        chk("fill_a_cnt", 32'(a_if.pending_count), 32'h8);
        chk("fill_b_cnt", 32'(b_if.pending_count), 32'h7);
        chk("fill_a_rp0", 32'(a_if.read_pending0), 32'h1);
        chk("fill_b_rp0", 32'(b_if.read_pending0), 32'h0);
        chk("fill_b_rp1", 32'(b_if.read_pending1), 32'h1);
        wr(0, 3'd3, 16'h1234);
        a_if.read_register0 = 3'd3;
        rst_n = 1'b0;
        #1;
        chk("mrst_a_cnt", 32'(a_if.pending_count), 32'h0);
        chk("mrst_b_cnt", 32'(b_if.pending_count), 32'h0);
        chk("mrst_a_rd0", 32'(a_if.read_data0), 32'h0);
        chk("mrst_a_rp1", 32'(a_if.read_pending1), 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        chk("lost_a_rd0", 32'(a_if.read_data0), 32'h0);
        chk("lost_b_rd0", 32'(b_if.read_data0), 32'h0);
        wr(0, 3'd0, 16'hBEEF);
        rsv(3'd0);
        a_if.read_register0 = 3'd0;
        #1;
        chk("z0_byp_b_rd0", 32'(b_if.read_data0), 32'h0);
        chk("z0_byp_a_rd0", 32'(a_if.read_data0), 32'hBEEF);
        tick();
        idle();
        #1;
        chk("z0_b_rd0", 32'(b_if.read_data0), 32'h0);
        chk("z0_b_rp0", 32'(b_if.read_pending0), 32'h0);
        chk("z0_b_cnt", 32'(b_if.pending_count), 32'h0);
        chk("z0_a_rd0", 32'(a_if.read_data0), 32'hBEEF);
        chk("z0_a_rp0", 32'(a_if.read_pending0), 32'h1);
        chk("z0_a_cnt", 32'(a_if.pending_count), 32'h1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
